tanh_act_seq: RTL and testbench



---
 rtl/tanh_act_pkg.sv | 48 ++++
 rtl/tanh_act_seq_mul.sv | 23 ++
 rtl/tanh_act_seq.sv | 172 +++++++++++++++++
 tb/tb_tanh_act_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_act_pkg.sv
// rtl/tanh_act_pkg.sv - shared types, coefficients and saturation helpers for tanh_act_seq
package tanh_act_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        HORNER,
        MULX,
        DONE
    } state_t;

    function automatic logic signed [63:0] one_q(input int frac_w);
        one_q = 64'sd1 <<< frac_w;
    endfunction

    function automatic logic signed [63:0] half_q(input int frac_w);
        half_q = 64'sd1 <<< (frac_w - 1);
    endfunction

    // Term i (1..4) of the odd series: C1, C3, C5, C7, each rounded to nearest
    function automatic logic signed [63:0] coef_term(input int i, input int frac_w);
        logic signed [63:0] one;
        one = one_q(frac_w);
        case (i)
            1:       coef_term = one;
            2:       coef_term = -((one * 64'sd2 + 64'sd3) / 64'sd6);
            3:       coef_term = (one * 64'sd4 + 64'sd15) / 64'sd30;
            4:       coef_term = -((one * 64'sd34 + 64'sd315) / 64'sd630);
            default: coef_term = 64'sd0;
        endcase
    endfunction

    // Clamp a wide signed value into the w-bit two's complement range
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            sat_to = hi;
        end else if (v < lo) begin
            sat_to = lo;
        end else begin
            sat_to = v;
        end
    endfunction

endpackage

// File: rtl/tanh_act_seq_mul.sv
// rtl/tanh_act_seq_mul.sv - fxp_mul_q: signed Q-format multiply with floor shift and saturation
module fxp_mul_q
    import tanh_act_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] p_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] prod_sh;

    // Full-width product, arithmetic shift floors toward -inf, then clamp
    always_comb begin
        prod    = a_i * b_i;
        prod_sh = prod >>> FRAC_W;
        p_o     = DATA_W'(sat_to(64'(prod_sh), DATA_W));
    end

endmodule

// File: rtl/tanh_act_seq.sv
// rtl/tanh_act_seq.sv - sequential Horner-form tanh engine; SIGMOID_EN adds sigmoid mode
module tanh_act_seq
    import tanh_act_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 12,
    parameter int TERMS      = 4,
    parameter int SAT_THRESH = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(TERMS + 1);
    localparam logic signed [DATA_W-1:0] ONE_Q    = DATA_W'(one_q(FRAC_W));
    localparam logic signed [DATA_W-1:0] C_TOP    = DATA_W'(coef_term(TERMS, FRAC_W));
    localparam logic signed [DATA_W:0]   THRESH_X = (DATA_W + 1)'(SAT_THRESH);

    state_t                   state_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] x2_q;
    logic signed [DATA_W-1:0] acc_q;
    logic signed [DATA_W-1:0] y_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;

    logic signed [DATA_W-1:0] x_eff;
    logic signed [DATA_W:0]   x_ext;
    logic signed [DATA_W:0]   abs_x;
    logic                     sat_hit;
    logic signed [DATA_W-1:0] mul_a;
    logic signed [DATA_W-1:0] mul_b;
    logic signed [DATA_W-1:0] mul_p;
    logic signed [DATA_W-1:0] horner_d;
    logic signed [DATA_W-1:0] fin_t;
    logic signed [DATA_W-1:0] y_fin;

`ifdef SIGMOID_EN
    logic mode_q;
    logic fin_mode;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Operand as seen by the series (halved for sigmoid) and its magnitude one bit wider
    always_comb begin
        x_eff = x_in;
`ifdef SIGMOID_EN
        if (mode) begin
            x_eff = $signed(x_in) >>> 1;
        end
`endif
        x_ext   = {x_eff[DATA_W-1], x_eff};
        abs_x   = x_ext[DATA_W] ? -x_ext : x_ext;
        sat_hit = (abs_x >= THRESH_X);
    end

    // Route the single multiplier according to the current step
    always_comb begin
        mul_a = x_q;
        mul_b = acc_q;
        case (state_q)
            SQ:      mul_b = x_q;
            HORNER:  mul_a = x2_q;
            default: ;
        endcase
    end

    fxp_mul_q #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W)
    ) u_mul (
        .a_i(mul_a),
        .b_i(mul_b),
        .p_o(mul_p)
    );

    // Horner step and the value loaded into y when entering DONE
    always_comb begin
        horner_d = DATA_W'(sat_to(coef_term(int'(cnt_q), FRAC_W) + 64'(mul_p), DATA_W));
        fin_t    = (state_q == IDLE) ? (x_eff[DATA_W-1] ? -ONE_Q : ONE_Q) : mul_p;
`ifdef SIGMOID_EN
        fin_mode = (state_q == IDLE) ? mode : mode_q;
        y_fin    = fin_mode ? DATA_W'(sat_to(half_q(FRAC_W) + 64'(fin_t >>> 1), DATA_W)) : fin_t;
`else
        y_fin    = fin_t;
`endif
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            x2_q        <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SIGMOID_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        x_q        <= x_eff;
`ifdef SIGMOID_EN
                        mode_q     <= mode;
`endif
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (sat_hit) begin
                            y_q         <= y_fin;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= SQ;
                        end
                    end
                end
                SQ: begin
                    x2_q    <= mul_p;
                    acc_q   <= C_TOP;
                    cnt_q   <= CNT_W'(TERMS - 1);
                    state_q <= (TERMS == 1) ? MULX : HORNER;
                end
                HORNER: begin
                    acc_q <= horner_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= MULX;
                    end
                end
                MULX: begin
                    y_q         <= y_fin;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tanh_act_seq.sv
// tb/tb_tanh_act_seq.sv - directed self-checking bench for tanh_act_seq
module tb_tanh_act_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_out;
    logic        busy;

    int checks;
    int errors;

    tanh_act_seq #(
        .DATA_W(16),
        .FRAC_W(12),
        .TERMS(4),
        .SAT_THRESH(4096)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x_in(x_in),
        .mode(mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out(y_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for in_ready, present one operand, count edges from the accept edge (=1) to out_valid
    task automatic run_op(input logic [15:0] x, input logic m, output int lat, output logic [15:0] y);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        x_in     = x;
        mode     = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = y_out;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || y_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b y_out=%0d required 0 0 0 0",
                     in_ready, out_valid, busy, y_out);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_poly;
        int lat;
        logic [15:0] y;
        run_op(16'd2458, 1'b0, lat, y);
        checks++;
        if (lat !== 6 || y !== 16'd2198) begin
            errors++;
            $display("FAIL poly_pos: latency=%0d y=%0d required 6 2198", lat, $signed(y));
        end
        run_op(-16'sd2458, 1'b0, lat, y);
        checks++;
        if (lat !== 6 || y !== -16'sd2199) begin
            errors++;
            $display("FAIL poly_neg: latency=%0d y=%0d required 6 -2199", lat, $signed(y));
        end
        run_op(16'd0, 1'b0, lat, y);
        checks++;
        if (lat !== 6 || y !== 16'd0) begin
            errors++;
            $display("FAIL poly_zero: latency=%0d y=%0d required 6 0", lat, $signed(y));
        end
    endtask

    task automatic test_saturate;
        int lat;
        logic [15:0] y;
        run_op(16'd12288, 1'b0, lat, y);
        checks++;
        if (lat !== 1 || y !== 16'd4096) begin
            errors++;
            $display("FAIL sat_pos: latency=%0d y=%0d required 1 4096", lat, $signed(y));
        end
        run_op(-16'sd12288, 1'b0, lat, y);
        checks++;
        if (lat !== 1 || y !== -16'sd4096) begin
            errors++;
            $display("FAIL sat_neg: latency=%0d y=%0d required 1 -4096", lat, $signed(y));
        end
        run_op(16'h8000, 1'b0, lat, y);
        checks++;
        if (lat !== 1 || y !== -16'sd4096) begin
            errors++;
            $display("FAIL sat_min: latency=%0d y=%0d required 1 -4096", lat, $signed(y));
        end
    endtask

    task automatic test_threshold;
        int lat;
        logic [15:0] y;
        run_op(16'd4095, 1'b0, lat, y);
        checks++;
        if (lat !== 6 || y !== 16'd3054) begin
            errors++;
            $display("FAIL thresh_below: latency=%0d y=%0d required 6 3054", lat, $signed(y));
        end
        run_op(16'd4096, 1'b0, lat, y);
        checks++;
        if (lat !== 1 || y !== 16'd4096) begin
            errors++;
            $display("FAIL thresh_at: latency=%0d y=%0d required 1 4096", lat, $signed(y));
        end
    endtask

`ifdef SIGMOID_EN
    task automatic test_sigmoid;
        int lat;
        logic [15:0] y;
        run_op(16'd0, 1'b1, lat, y);
        checks++;
        if (lat !== 6 || y !== 16'd2048) begin
            errors++;
            $display("FAIL sigmoid_zero: latency=%0d y=%0d required 6 2048", lat, $signed(y));
        end
        run_op(16'd12288, 1'b1, lat, y);
        checks++;
        if (lat !== 1 || y !== 16'd4096) begin
            errors++;
            $display("FAIL sigmoid_sat: latency=%0d y=%0d required 1 4096", lat, $signed(y));
        end
    endtask
`endif

    task automatic test_hold;
        int lat;
        logic [15:0] y;
        out_ready = 1'b0;
        run_op(16'd12288, 1'b0, lat, y);
        checks++;
        if (lat !== 1 || y !== 16'd4096) begin
            errors++;
            $display("FAIL hold_first: latency=%0d y=%0d required 1 4096", lat, $signed(y));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 1);
            x_in     = -16'sd12288;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || y_out !== 16'd4096 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: out_valid=%b y=%0d in_ready=%b required 1 4096 0",
                         i, out_valid, $signed(y_out), in_ready);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = -16'sd12288;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || y_out !== -16'sd4096) begin
            errors++;
            $display("FAIL hold_next_accept: out_valid=%b y=%0d required 1 -4096", out_valid, $signed(y_out));
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [15:0] y;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'd2458;
        mode     = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || y_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_horner: out_valid=%b busy=%b in_ready=%b y=%0d required 0 0 0 0",
                     out_valid, busy, in_ready, $signed(y_out));
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        run_op(16'd12288, 1'b0, lat, y);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        run_op(16'd2458, 1'b0, lat, y);
        checks++;
        if (lat !== 6 || y !== 16'd2198) begin
            errors++;
            $display("FAIL after_reset: latency=%0d y=%0d required 6 2198", lat, $signed(y));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        x_in      = 16'd0;
        mode      = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_poly();
        test_saturate();
        test_threshold();
`ifdef SIGMOID_EN
        test_sigmoid();
`endif
        test_hold();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
